// File: rtl/dot_product_sequencer_if.sv
// Bundles the operand stream, multiplier A/B/P path and result handshake of dot_product_sequencer.
// slave: the sequencer side. master: the environment, i.e. the operand source, the multiplier and the result sink.
interface dot_product_sequencer_if;
  logic               in_valid;
  logic               in_ready;
  logic signed [17:0] in_a;
  logic signed [17:0] in_b;
  logic signed [17:0] MUL_A;
  logic signed [17:0] MUL_B;
  logic signed [35:0] MUL_P;
  logic               out_valid;
  logic               out_ready;
  logic signed [17:0] out_data;
  logic               out_overflow;

  modport slave (
    input  in_valid, in_a, in_b, MUL_P, out_ready,
    output in_ready, MUL_A, MUL_B, out_valid, out_data, out_overflow
  );

  modport master (
    output in_valid, in_a, in_b, MUL_P, out_ready,
    input  in_ready, MUL_A, MUL_B, out_valid, out_data, out_overflow
  );
endinterface

// File: rtl/dot_product_sequencer.sv
// Streams LENGTH operand pairs through an external pipelined multiplier, accumulates, rescales and saturates.
// Optional macro DOT_ROUND_EN: round half up before the FRAC_BITS shift instead of floor truncation.
module dot_product_sequencer #(
  parameter int LENGTH      = 4,
  parameter int MUL_LATENCY = 3,
  parameter int FRAC_BITS   = 8,
  parameter int ACC_WIDTH   = 48
) (
  input logic CLK,
  input logic RST,
  dot_product_sequencer_if.slave bus
);

  localparam int CNT_W = $clog2(LENGTH + 1);

  localparam logic [1:0] ACCEPT = 2'd0;
  localparam logic [1:0] DRAIN  = 2'd1;
  localparam logic [1:0] RESULT = 2'd2;
  localparam logic [1:0] OUTPUT = 2'd3;

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'(131071);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ACC_WIDTH'(-131072);

`ifdef DOT_ROUND_EN
  localparam logic signed [ACC_WIDTH-1:0] ROUND_K =
    (FRAC_BITS > 0) ? ACC_WIDTH'(64'd1 << ((FRAC_BITS > 0) ? FRAC_BITS - 1 : 0)) : '0;
`endif

  logic [1:0]                  state;
  logic [CNT_W-1:0]            fire_cnt;
  logic [CNT_W-1:0]            prod_cnt;
  logic [MUL_LATENCY-1:0]      tag;
  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] product_ext;
  logic signed [ACC_WIDTH-1:0] rounded;
  logic signed [ACC_WIDTH-1:0] shifted;
  logic signed [17:0]          sat_data;
  logic                        sat_ovf;
  logic                        fire;
  logic                        prod_take;
  logic signed [17:0]          data_q;
  logic                        ovf_q;
  logic                        valid_q;

  assign bus.in_ready     = (state == ACCEPT) && !RST;
  assign fire             = bus.in_valid && bus.in_ready;
  assign bus.MUL_A        = fire ? bus.in_a : '0;
  assign bus.MUL_B        = fire ? bus.in_b : '0;
  assign bus.out_valid    = valid_q;
  assign bus.out_data     = data_q;
  assign bus.out_overflow = ovf_q;

  // The top tag bit marks the cycle in which MUL_P carries one of our products; anything else on P is stale.
  assign prod_take   = tag[MUL_LATENCY-1];
  assign product_ext = {{(ACC_WIDTH-36){bus.MUL_P[35]}}, bus.MUL_P};

  always_comb begin
    rounded = acc;
`ifdef DOT_ROUND_EN
    rounded = acc + ROUND_K;
`endif
    shifted  = rounded >>> FRAC_BITS;
    sat_data = shifted[17:0];
    sat_ovf  = 1'b0;
    if (shifted > SAT_MAX) begin
      sat_data = 18'sd131071;
      sat_ovf  = 1'b1;
    end else if (shifted < SAT_MIN) begin
      sat_data = -18'sd131072;
      sat_ovf  = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= ACCEPT;
      fire_cnt <= '0;
      prod_cnt <= '0;
      tag      <= '0;
      acc      <= '0;
      data_q   <= '0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      tag <= (tag << 1) | MUL_LATENCY'(fire);
      if (prod_take) begin
        acc      <= acc + product_ext;
        prod_cnt <= prod_cnt + 1'b1;
      end
      if (fire) begin
        fire_cnt <= fire_cnt + 1'b1;
      end
      case (state)
        ACCEPT: begin
          if (fire && (fire_cnt == CNT_W'(LENGTH - 1))) begin
            state <= DRAIN;
          end
        end
        // Wait on the registered product count so RESULT always sees the fully updated sum.
        DRAIN: begin
          if (prod_cnt == CNT_W'(LENGTH)) begin
            state <= RESULT;
          end
        end
        RESULT: begin
          data_q  <= sat_data;
          ovf_q   <= sat_ovf;
          valid_q <= 1'b1;
          state   <= OUTPUT;
        end
        OUTPUT: begin
          if (bus.out_ready) begin
            valid_q  <= 1'b0;
            acc      <= '0;
            fire_cnt <= '0;
            prod_cnt <= '0;
            state    <= ACCEPT;
          end
        end
        default: state <= ACCEPT;
      endcase
    end
  end

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Scoreboard bench for dot_product_sequencer with a 3-stage multiplier model whose registers start with garbage.
// Build with DOT_ROUND_EN defined to check the rounding variant.
module tb_dot_product_sequencer;

  logic CLK;
  logic RST;
  int   checks;
  int   errors;

  dot_product_sequencer_if bus ();

  dot_product_sequencer #(
    .LENGTH(4), .MUL_LATENCY(3), .FRAC_BITS(8), .ACC_WIDTH(48)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Multiplier model is deliberately not reset so the DUT must ignore whatever sits in it.
  logic signed [35:0] mul_s1 = 36'sh1_2345_6789;
  logic signed [35:0] mul_s2 = 36'sh7_0F0F_0F0F;
  logic signed [35:0] mul_s3 = 36'sh3_CAFE_BABE;
  always @(posedge CLK) begin
    mul_s1 <= 36'(bus.MUL_A) * 36'(bus.MUL_B);
    mul_s2 <= mul_s1;
    mul_s3 <= mul_s2;
  end
  assign bus.MUL_P = mul_s3;

`ifdef DOT_ROUND_EN
  localparam longint EXP_HALF_UP  = 1;
  localparam longint EXP_MINUS_ONE = 0;
`else
  localparam longint EXP_HALF_UP  = 0;
  localparam longint EXP_MINUS_ONE = -1;
`endif

  typedef struct {
    longint data;
    longint ovf;
  } exp_t;

  exp_t exp_q[$];
  logic signed [17:0] va[4];
  logic signed [17:0] vb[4];

  task automatic check_output(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Monitor: whenever a result is presented it must match the oldest expectation, and stay put until taken.
  always @(negedge CLK) begin
    if (!RST && bus.out_valid) begin
      if (exp_q.size() == 0) begin
        check_output("unexpected_result", 1, 0);
      end else begin
        check_output("out_data", bus.out_data, exp_q[0].data);
        check_output("out_overflow", bus.out_overflow, exp_q[0].ovf);
        if (bus.out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_pair(input logic signed [17:0] a, input logic signed [17:0] b);
    int n;
    n = 0;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 200) begin
      tick();
      n++;
    end
    if (!bus.in_ready) check_output("in_ready_timeout", 0, 1);
    tick();
    bus.in_valid = 1'b0;
    bus.in_a     = '0;
    bus.in_b     = '0;
  endtask

  task automatic apply_stimulus(input int gap, input longint exp_data, input longint exp_ovf);
    exp_t e;
    e.data = exp_data;
    e.ovf  = exp_ovf;
    exp_q.push_back(e);
    for (int i = 0; i < 4; i++) begin
      send_pair(va[i], vb[i]);
      if (gap > 0 && i < 3) repeat (gap) tick();
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) check_output("result_timeout", exp_q.size(), 0);
    tick();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    checks = 0;
    errors = 0;
    RST = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b1;

    repeat (3) tick();
    check_output("rst_in_ready", bus.in_ready, 0);
    check_output("rst_out_valid", bus.out_valid, 0);
    check_output("rst_out_data", bus.out_data, 0);
    check_output("rst_out_overflow", bus.out_overflow, 0);
    RST = 1'b0;
    tick();
    check_output("idle_in_ready", bus.in_ready, 1);
    check_output("idle_mul_a", bus.MUL_A, 0);

    // Basic vector, plus latency and in_ready held low until the handshake.
    va = '{256, 256, 256, 256};
    vb = '{256, 256, 256, 256};
    apply_stimulus(0, 1024, 0);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      check_output("busy_in_ready", bus.in_ready, 0);
      tick();
      n++;
    end
    check_output("latency_edges", n, 5);
    check_output("output_in_ready", bus.in_ready, 0);
    wait_drain();

    va = '{131071, 131071, 131071, 131071};
    vb = '{131071, 131071, 131071, 131071};
    apply_stimulus(0, 131071, 1);
    wait_drain();

    va = '{-131072, -131072, -131072, -131072};
    vb = '{131071, 131071, 131071, 131071};
    apply_stimulus(0, -131072, 1);
    wait_drain();

    va = '{-256, 0, 0, 0};
    vb = '{256, 5, 5, 5};
    apply_stimulus(2, -256, 0);
    wait_drain();

    va = '{1, 0, 0, 0};
    vb = '{128, 0, 0, 0};
    apply_stimulus(0, EXP_HALF_UP, 0);
    wait_drain();

    va = '{-1, 0, 0, 0};
    vb = '{1, 0, 0, 0};
    apply_stimulus(0, EXP_MINUS_ONE, 0);
    wait_drain();

    // Backpressure: result held, no new pair accepted, multiplier inputs quiet.
    bus.out_ready = 1'b0;
    va = '{256, 256, 256, 256};
    vb = '{256, 256, 256, 256};
    apply_stimulus(0, 1024, 0);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      tick();
      n++;
    end
    bus.in_valid = 1'b1;
    bus.in_a     = 18'sd256;
    bus.in_b     = 18'sd256;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_output("hold_out_valid", bus.out_valid, 1);
      check_output("hold_in_ready", bus.in_ready, 0);
      check_output("hold_mul_a", bus.MUL_A, 0);
      check_output("hold_mul_b", bus.MUL_B, 0);
    end
    bus.out_ready = 1'b1;
    tick();
    check_output("post_handshake_out_valid", bus.out_valid, 0);
    check_output("post_handshake_in_ready", bus.in_ready, 1);
    apply_stimulus(0, 1024, 0);
    wait_drain();

    // Reset during DRAIN with products still in flight; nothing from that vector may surface.
    va = '{1000, 1000, 1000, 1000};
    vb = '{1000, 1000, 1000, 1000};
    for (int i = 0; i < 4; i++) send_pair(va[i], vb[i]);
    tick();
    RST = 1'b1;
    tick();
    check_output("midrst_out_valid", bus.out_valid, 0);
    check_output("midrst_in_ready", bus.in_ready, 0);
    RST = 1'b0;
    tick();
    check_output("after_rst_in_ready", bus.in_ready, 1);
    va = '{256, 256, 256, 256};
    vb = '{256, 256, 256, 256};
    apply_stimulus(0, 1024, 0);
    wait_drain();
    repeat (10) tick();
    check_output("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
